// File: rtl/load_store_unit.sv
// RV32I load/store unit: word-addressed memory initiator with sub-word RMW stores.
// Optional LSU_PERF_EN macro adds saturating load/store/error counters.
module load_store_unit #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int MEM_WORDS     = 2**17
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     is_store,
   input  logic [2:0]               funct3,
   input  logic [ADDRESS_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0]    wdata,
   output logic                     resp_valid,
   output logic                     resp_err,
   output logic [DATA_WIDTH-1:0]    rdata,
   output logic                     mem_we,
   output logic [ADDRESS_WIDTH-3:0] mem_a,
   output logic [DATA_WIDTH-1:0]    mem_wd,
   input  logic [DATA_WIDTH-1:0]    mem_rd
`ifdef LSU_PERF_EN
   ,
   output logic [15:0]              load_cnt,
   output logic [15:0]              store_cnt,
   output logic [15:0]              err_cnt
`endif
);

   localparam logic [ADDRESS_WIDTH-1:0] MEM_LIM = ADDRESS_WIDTH'(MEM_WORDS);

   typedef enum logic [1:0] {IDLE, ACCESS, RMW_WR, RESP} state_t;

   typedef struct packed {
      logic                     st;
      logic [2:0]               f3;
      logic [ADDRESS_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0]    wdata;
      logic                     err;
   } req_t;

   state_t                state, next;
   req_t                  rq;
   logic                  accept;
   logic                  req_err;
   logic                  word_op;
   logic [DATA_WIDTH-1:0] old_q;
   logic [DATA_WIDTH-1:0] shifted;
   logic [DATA_WIDTH-1:0] ld_ext;
   logic [DATA_WIDTH-1:0] merged;

   assign accept  = req_valid && req_ready;
   assign word_op = (rq.f3[1:0] == 2'b10);
   assign mem_a   = rq.addr[ADDRESS_WIDTH-1:2];

   always_comb begin
      req_err = 1'b0;
      if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111)
         req_err = 1'b1;
      if (is_store && funct3[2])
         req_err = 1'b1;
      if (funct3[1:0] == 2'b01 && addr[0])
         req_err = 1'b1;
      if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00)
         req_err = 1'b1;
      if ({2'b00, addr[ADDRESS_WIDTH-1:2]} >= MEM_LIM)
         req_err = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= next;
   end

   always_comb begin
      next = state;
      unique case (state)
         IDLE:
            if (accept)
               next = req_err ? RESP : ACCESS;
         ACCESS:
            next = (rq.st && !word_op) ? RMW_WR : RESP;
         RMW_WR:
            next = RESP;
         RESP:
            next = IDLE;
         default:
            next = IDLE;
      endcase
   end

   always_comb begin
      req_ready  = (state == IDLE);
      resp_valid = (state == RESP);
      mem_we     = 1'b0;
      mem_wd     = '0;
      if (state == ACCESS && rq.st && word_op) begin
         mem_we = 1'b1;
         mem_wd = rq.wdata;
      end
      if (state == RMW_WR) begin
         mem_we = 1'b1;
         mem_wd = merged;
      end
      // a write must never reach memory during a reset cycle
      if (rst)
         mem_we = 1'b0;
   end

   assign shifted = mem_rd >> {rq.addr[1:0], 3'b000};

   always_comb begin
      ld_ext = mem_rd;
      unique case (1'b1)
         rq.f3[1:0] == 2'b00:
            ld_ext = {{24{shifted[7] & ~rq.f3[2]}}, shifted[7:0]};
         rq.f3[1:0] == 2'b01:
            ld_ext = {{16{shifted[15] & ~rq.f3[2]}}, shifted[15:0]};
         default:
            ld_ext = mem_rd;
      endcase
   end

   always_comb begin
      merged = old_q;
      if (rq.f3[0]) begin
         if (rq.addr[1])
            merged[31:16] = rq.wdata[15:0];
         else
            merged[15:0] = rq.wdata[15:0];
      end else begin
         unique case (rq.addr[1:0])
            2'b00: merged[7:0]   = rq.wdata[7:0];
            2'b01: merged[15:8]  = rq.wdata[7:0];
            2'b10: merged[23:16] = rq.wdata[7:0];
            2'b11: merged[31:24] = rq.wdata[7:0];
            default: merged = old_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rq    <= '0;
         old_q <= '0;
      end else begin
         if (accept) begin
            rq.st    <= is_store;
            rq.f3    <= funct3;
            rq.addr  <= addr;
            rq.wdata <= wdata;
            rq.err   <= req_err;
         end
         if (state == ACCESS && rq.st && !word_op)
            old_q <= mem_rd;
      end
   end

   // results change only as RESP is entered, so they hold between responses
   always_ff @(posedge clk) begin
      if (rst) begin
         resp_err <= 1'b0;
         rdata    <= '0;
      end else if (next == RESP && state != RESP) begin
         resp_err <= (state == IDLE);
         rdata    <= (state == ACCESS && !rq.st) ? ld_ext : '0;
      end
   end

`ifdef LSU_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         load_cnt  <= '0;
         store_cnt <= '0;
         err_cnt   <= '0;
      end else if (state == RESP) begin
         if (rq.err) begin
            if (err_cnt != 16'hFFFF)
               err_cnt <= err_cnt + 16'd1;
         end else if (rq.st) begin
            if (store_cnt != 16'hFFFF)
               store_cnt <= store_cnt + 16'd1;
         end else begin
            if (load_cnt != 16'hFFFF)
               load_cnt <= load_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small behavioural word memory.
// Counter checks are compiled in when LSU_PERF_EN is defined.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        is_store;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] rdata;
   logic        mem_we;
   logic [29:0] mem_a;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;
`ifdef LSU_PERF_EN
   logic [15:0] load_cnt;
   logic [15:0] store_cnt;
   logic [15:0] err_cnt;
`endif

   logic [31:0] mem [0:63];
   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   load_store_unit dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .is_store   (is_store),
      .funct3     (funct3),
      .addr       (addr),
      .wdata      (wdata),
      .resp_valid (resp_valid),
      .resp_err   (resp_err),
      .rdata      (rdata),
      .mem_we     (mem_we),
      .mem_a      (mem_a),
      .mem_wd     (mem_wd),
`ifdef LSU_PERF_EN
      .load_cnt   (load_cnt),
      .store_cnt  (store_cnt),
      .err_cnt    (err_cnt),
`endif
      .mem_rd     (mem_rd)
   );

   assign mem_rd = mem[mem_a[5:0]];

   always @(posedge clk)
      if (mem_we)
         mem[mem_a[5:0]] <= mem_wd;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic do_req(input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output int wes,
                         output logic err, output logic [31:0] rd);
      @(negedge clk);
      req_valid = 1'b1;
      is_store  = st;
      funct3    = f3;
      addr      = a;
      wdata     = wd;
      lat = 99;
      wes = 0;
      err = 1'bx;
      rd  = 'x;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (mem_we)
            wes++;
         if (resp_valid) begin
            lat = i;
            err = resp_err;
            rd  = rdata;
            break;
         end
      end
   endtask

   int          lat, wes, bad, nresp;
   logic        err;
   logic [31:0] rd, rd2;

   initial begin
      for (int i = 0; i < 64; i++)
         mem[i] = 32'h0;
      mem[5] = 32'hDEADBEEF;
      rst = 1'b1;
      req_valid = 1'b0;
      is_store = 1'b0;
      funct3 = 3'b000;
      addr = '0;
      wdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_rvalid", {31'b0, resp_valid}, 32'd0);
      chk("rst_err", {31'b0, resp_err}, 32'd0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_we", {31'b0, mem_we}, 32'd0);
      chk("rst_a", {2'b0, mem_a}, 32'h0);
      chk("rst_wd", mem_wd, 32'h0);
      rst = 1'b0;

      do_req(1'b0, 3'b010, 32'h14, 32'h0, lat, wes, err, rd);
      chk("lw_lat", lat, 2);
      chk("lw_data", rd, 32'hDEADBEEF);
      chk("lw_err", {31'b0, err}, 32'd0);
      chk("lw_we", wes, 0);

      do_req(1'b0, 3'b000, 32'h17, 32'h0, lat, wes, err, rd);
      chk("lb_data", rd, 32'hFFFFFFDE);
      do_req(1'b0, 3'b100, 32'h17, 32'h0, lat, wes, err, rd);
      chk("lbu_data", rd, 32'h000000DE);
      do_req(1'b0, 3'b001, 32'h16, 32'h0, lat, wes, err, rd);
      chk("lh_data", rd, 32'hFFFFDEAD);
      do_req(1'b0, 3'b101, 32'h14, 32'h0, lat, wes, err, rd);
      chk("lhu_data", rd, 32'h0000BEEF);
      repeat (2) @(negedge clk);
      chk("hold_rdata", rdata, 32'h0000BEEF);
      chk("hold_rvalid", {31'b0, resp_valid}, 32'd0);

      do_req(1'b1, 3'b000, 32'h15, 32'h12345677, lat, wes, err, rd);
      chk("sb_lat", lat, 3);
      chk("sb_we", wes, 1);
      chk("sb_mem", mem[5], 32'hDEAD77EF);
      chk("sb_rdata", rd, 32'h0);

      do_req(1'b1, 3'b001, 32'h15, 32'h0000FFFF, lat, wes, err, rd);
      chk("sh_mis_lat", lat, 1);
      chk("sh_mis_err", {31'b0, err}, 32'd1);
      chk("sh_mis_we", wes, 0);
      chk("sh_mis_mem", mem[5], 32'hDEAD77EF);

      do_req(1'b0, 3'b011, 32'h14, 32'h0, lat, wes, err, rd);
      chk("f3_011_err", {31'b0, err}, 32'd1);
      chk("f3_011_rd", rd, 32'h0);
      do_req(1'b0, 3'b010, 32'h80000, 32'h0, lat, wes, err, rd);
      chk("oor_err", {31'b0, err}, 32'd1);
      do_req(1'b0, 3'b010, 32'h7FFFC, 32'h0, lat, wes, err, rd);
      chk("top_word_ok", {31'b0, err}, 32'd0);
      do_req(1'b1, 3'b100, 32'h14, 32'h0, lat, wes, err, rd);
      chk("st_f3_100_err", {31'b0, err}, 32'd1);
      chk("st_f3_100_we", wes, 0);
      do_req(1'b0, 3'b010, 32'h16, 32'h0, lat, wes, err, rd);
      chk("lw_mis_err", {31'b0, err}, 32'd1);

      do_req(1'b1, 3'b001, 32'h16, 32'h0000CAFE, lat, wes, err, rd);
      chk("sh_lat", lat, 3);
      chk("sh_err", {31'b0, err}, 32'd0);
      chk("sh_mem", mem[5], 32'hCAFE77EF);

      // reset during the ACCESS cycle of an SB
      @(negedge clk);
      req_valid = 1'b1;
      is_store = 1'b1;
      funct3 = 3'b000;
      addr = 32'h14;
      wdata = 32'h000000AA;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         #1 if (mem_we || resp_valid) bad++;
         @(negedge clk);
      end
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1 if (mem_we || resp_valid) bad++;
         @(negedge clk);
      end
      chk("rst_acc_quiet", bad, 0);
      chk("rst_acc_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_acc_mem", mem[5], 32'hCAFE77EF);

      // reset landing in the RMW write cycle
      req_valid = 1'b1;
      is_store = 1'b1;
      funct3 = 3'b000;
      addr = 32'h14;
      wdata = 32'h000000AA;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1 chk("rst_rmw_we", {31'b0, mem_we}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_rmw_mem", mem[5], 32'hCAFE77EF);
      chk("rst_rmw_rvalid", {31'b0, resp_valid}, 32'd0);

      // back-to-back SW then LW with req_valid held
      @(negedge clk);
      req_valid = 1'b1;
      is_store = 1'b1;
      funct3 = 3'b010;
      addr = 32'h20;
      wdata = 32'h13579BDF;
      @(posedge clk);
      #1;
      is_store = 1'b0;
      wdata = 32'h0;
      nresp = 0;
      bad = 0;
      rd2 = 32'h0;
      for (int i = 0; i < 12 && nresp < 2; i++) begin
         @(negedge clk);
         if (resp_valid) begin
            nresp++;
            if (req_ready) bad++;
            if (nresp == 2) rd2 = rdata;
         end else if (nresp == 1 && req_ready && req_valid) begin
            @(posedge clk);
            #1 req_valid = 1'b0;
         end
      end
      req_valid = 1'b0;
      chk("b2b_nresp", nresp, 2);
      chk("b2b_ready_low", bad, 0);
      chk("b2b_mem", mem[8], 32'h13579BDF);
      chk("b2b_rdata", rd2, 32'h13579BDF);
`ifdef LSU_PERF_EN
      @(negedge clk);
      chk("cnt_load", {16'b0, load_cnt}, 32'd1);
      chk("cnt_store", {16'b0, store_cnt}, 32'd1);
      chk("cnt_err", {16'b0, err_cnt}, 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
